// File: rtl/vote_collector.sv
// Sequential majority vote collector: gathers one tagged ballot per handshake,
// rejects duplicate and out-of-range voter IDs, then latches the majority decision.
module vote_collector #(
    parameter int N_VOTERS = 5,
    parameter int ID_W     = 3,
    parameter int TIMEOUT  = 32,
    parameter int CNT_W    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             vote_valid,
    output logic             vote_ready,
    input  logic [ID_W-1:0]  vote_id,
    input  logic             vote_val,
    output logic             busy,
    output logic             done,
    output logic             result,
    output logic [CNT_W-1:0] yes_cnt,
    output logic [CNT_W-1:0] no_cnt,
    output logic             reject,
    output logic             timed_out
);

    localparam int TIMER_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);
    // One extra bit so N_VOTERS == 2**ID_W does not truncate to zero.
    localparam logic [ID_W:0]      ID_LIMIT   = (ID_W + 1)'(N_VOTERS);
    localparam logic [CNT_W-1:0]   MAJ_THRESH = CNT_W'(N_VOTERS / 2);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t              state, state_next;
    logic [N_VOTERS-1:0] mask, mask_next, id_onehot;
    logic [CNT_W-1:0]    yes_next, no_next;
    logic [TIMER_W-1:0]  timer, timer_next;
    logic                result_next, timed_out_next, reject_next;
    logic                handshake, in_range, duplicate, accept, discard;

    assign vote_ready = (state == COLLECT);
    assign busy       = (state == COLLECT);
    assign done       = (state == DONE);

    assign handshake = vote_valid & vote_ready;
    assign in_range  = ({1'b0, vote_id} < ID_LIMIT);
    assign id_onehot = N_VOTERS'(1) << vote_id;
    assign duplicate = |(mask & id_onehot);
    assign accept    = handshake & in_range & ~duplicate;
    assign discard   = handshake & ~accept;

    // NOTE: every variable gets its default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_next     = state;
        mask_next      = mask;
        yes_next       = yes_cnt;
        no_next        = no_cnt;
        timer_next     = timer;
        result_next    = result;
        timed_out_next = timed_out;
        reject_next    = 1'b0;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_next     = COLLECT;
                    mask_next      = '0;
                    yes_next       = '0;
                    no_next        = '0;
                    timer_next     = '0;
                    result_next    = 1'b0;
                    timed_out_next = 1'b0;
                end
            end
            COLLECT: begin
                timer_next  = timer + TIMER_W'(1);
                reject_next = discard;
                if (accept) begin
                    mask_next = mask | id_onehot;
                    if (vote_val) yes_next = yes_cnt + CNT_W'(1);
                    else          no_next  = no_cnt + CNT_W'(1);
                end
                // A ballot landing on the last timer cycle is counted before deciding timed_out.
                if ((&mask_next) || (timer == TIMER_LAST)) begin
                    state_next     = DONE;
                    timer_next     = '0;
                    result_next    = (yes_next > MAJ_THRESH);
                    timed_out_next = ~(&mask_next);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            mask      <= '0;
            yes_cnt   <= '0;
            no_cnt    <= '0;
            timer     <= '0;
            result    <= 1'b0;
            timed_out <= 1'b0;
            reject    <= 1'b0;
        end else begin
            state     <= state_next;
            mask      <= mask_next;
            yes_cnt   <= yes_next;
            no_cnt    <= no_next;
            timer     <= timer_next;
            result    <= result_next;
            timed_out <= timed_out_next;
            reject    <= reject_next;
        end
    end

endmodule

// File: tb/tb_vote_collector.sv
// Randomised self-checking bench for vote_collector against a ballot-level reference model.
module tb_vote_collector;

    localparam int N_VOTERS = 5;
    localparam int ID_W     = 3;
    localparam int TIMEOUT  = 32;
    localparam int CNT_W    = 3;

    typedef struct {
        bit            v;
        bit [ID_W-1:0] id;
        bit            val;
    } ballot_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             vote_valid = 1'b0;
    logic             vote_ready;
    logic [ID_W-1:0]  vote_id = '0;
    logic             vote_val = 1'b0;
    logic             busy, done, result, reject, timed_out;
    logic [CNT_W-1:0] yes_cnt, no_cnt;

    int checks = 0;
    int failures = 0;
    ballot_t stim[$];

    vote_collector #(
        .N_VOTERS(N_VOTERS), .ID_W(ID_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .vote_valid(vote_valid),
        .vote_ready(vote_ready), .vote_id(vote_id), .vote_val(vote_val),
        .busy(busy), .done(done), .result(result), .yes_cnt(yes_cnt),
        .no_cnt(no_cnt), .reject(reject), .timed_out(timed_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Ballot-level model: walk the offered ballots cycle by cycle of the open window.
    task automatic model(output int k_close, output int ey, output int en,
                         output int erej, output bit eto, output bit eres);
        bit seen[N_VOTERS];
        int acc = 0;
        ey = 0; en = 0; erej = 0; eto = 0; k_close = -1;
        for (int i = 0; i < N_VOTERS; i++) seen[i] = 0;
        for (int k = 0; k < TIMEOUT; k++) begin
            if (k < stim.size() && stim[k].v) begin
                if (int'(stim[k].id) < N_VOTERS && !seen[stim[k].id]) begin
                    seen[stim[k].id] = 1;
                    acc++;
                    if (stim[k].val) ey++; else en++;
                end else begin
                    erej++;
                end
            end
            if (acc == N_VOTERS || k == TIMEOUT - 1) begin
                k_close = k;
                eto = (acc != N_VOTERS);
                break;
            end
        end
        eres = (2 * ey > N_VOTERS);
    endtask

    // Opens a ballot, plays stim one entry per cycle and compares the closed ballot with the model.
    task automatic run_ballot(input string name, output bit got_result);
        int k_close, ey, en, erej, rej_seen, close_edge;
        bit eto, eres;
        model(k_close, ey, en, erej, eto, eres);
        rej_seen = 0;
        close_edge = -1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < TIMEOUT + 4; k++) begin
            if (k < stim.size()) begin
                vote_valid = stim[k].v;
                vote_id    = stim[k].id;
                vote_val   = stim[k].val;
            end else begin
                vote_valid = 1'b0;
            end
            tick();
            if (reject === 1'b1) rej_seen++;
            if (done === 1'b1) begin
                close_edge = k;
                break;
            end
        end
        vote_valid = 1'b0;
        got_result = result;
        checks++;
        if (close_edge != k_close) begin
            failures++;
            $display("FAIL %s close_cycle got=%0d exp=%0d", name, close_edge, k_close);
        end
        checks++;
        if (yes_cnt !== CNT_W'(ey) || no_cnt !== CNT_W'(en)) begin
            failures++;
            $display("FAIL %s counts got yes=%0d no=%0d exp yes=%0d no=%0d", name, yes_cnt, no_cnt, ey, en);
        end
        checks++;
        if (result !== eres || timed_out !== eto) begin
            failures++;
            $display("FAIL %s result/timed_out got=%b/%b exp=%b/%b", name, result, timed_out, eres, eto);
        end
        checks++;
        if (rej_seen != erej) begin
            failures++;
            $display("FAIL %s reject_pulses got=%0d exp=%0d", name, rej_seen, erej);
        end
        checks++;
        if (busy !== 1'b0 || vote_ready !== 1'b0) begin
            failures++;
            $display("FAIL %s busy/ready in done got=%b/%b exp=0/0", name, busy, vote_ready);
        end
        tick();
        checks++;
        if (reject !== 1'b0 || done !== 1'b1) begin
            failures++;
            $display("FAIL %s hold got reject=%b done=%b exp reject=0 done=1", name, reject, done);
        end
    endtask

    task automatic push(input bit v, input int id, input bit val);
        ballot_t b;
        b.v = v;
        b.id = ID_W'(id);
        b.val = val;
        stim.push_back(b);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        checks++;
        if ({vote_ready, busy, done, result, reject, timed_out} !== 6'b0 || yes_cnt !== '0 || no_cnt !== '0) begin
            failures++;
            $display("FAIL reset outputs got rdy=%b busy=%b done=%b res=%b rej=%b to=%b yes=%0d no=%0d exp all 0",
                     vote_ready, busy, done, result, reject, timed_out, yes_cnt, no_cnt);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_full_ballot();
        bit r;
        stim.delete();
        push(1, 0, 1); push(1, 1, 1); push(1, 2, 1); push(1, 3, 0); push(1, 4, 0);
        run_ballot("full_ballot", r);
    endtask

    task automatic test_duplicate();
        bit r;
        stim.delete();
        push(1, 0, 1); push(1, 1, 1); push(1, 1, 1); push(1, 2, 0); push(1, 3, 0); push(1, 4, 0);
        run_ballot("duplicate", r);
    endtask

    task automatic test_timeout();
        bit r;
        stim.delete();
        push(1, 6, 0); push(1, 0, 1); push(1, 1, 1); push(1, 2, 1);
        run_ballot("timeout", r);
    endtask

    task automatic test_last_cycle_ballot();
        bit r;
        stim.delete();
        for (int i = 0; i < 4; i++) push(1, i, i[0]);
        while (stim.size() < TIMEOUT - 1) push(0, 0, 0);
        push(1, 4, 1);
        run_ballot("last_cycle_ballot", r);
    endtask

    task automatic test_async_reset_and_sweep();
        bit r;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            vote_valid = 1'b1;
            vote_id    = ID_W'(i);
            vote_val   = 1'b1;
            tick();
        end
        vote_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({vote_ready, busy, done, result, reject, timed_out} !== 6'b0 || yes_cnt !== '0 || no_cnt !== '0) begin
            failures++;
            $display("FAIL async_reset got busy=%b done=%b yes=%0d no=%0d exp all 0", busy, done, yes_cnt, no_cnt);
        end
        #2 rst = 1'b0;
        tick();
        for (int p = 0; p < 32; p++) begin
            stim.delete();
            for (int i = 0; i < N_VOTERS; i++) push(1, i, p[i]);
            run_ballot("sweep", r);
            checks++;
            if (r !== ($countones(p) >= 3)) begin
                failures++;
                $display("FAIL sweep_majority pattern=%0d got=%b exp=%b", p, r, $countones(p) >= 3);
            end
        end
    endtask

    task automatic test_random();
        bit r;
        for (int n = 0; n < 40; n++) begin
            int len;
            stim.delete();
            len = $urandom_range(0, 40);
            for (int k = 0; k < len; k++)
                push($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 1) != 0);
            run_ballot("random", r);
        end
    endtask

    task automatic test_done_hold();
        bit r;
        logic [CNT_W-1:0] y0, n0;
        stim.delete();
        push(1, 0, 1); push(1, 1, 0); push(1, 2, 1); push(1, 3, 1); push(1, 4, 0);
        run_ballot("done_hold_setup", r);
        y0 = 3'd3;
        n0 = 3'd2;
        vote_valid = 1'b1;
        vote_id    = '0;
        vote_val   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (vote_ready !== 1'b0) begin
                failures++;
                $display("FAIL done_ready got=%b exp=0", vote_ready);
            end
            tick();
            checks++;
            if (yes_cnt !== y0 || no_cnt !== n0 || reject !== 1'b0 || done !== 1'b1) begin
                failures++;
                $display("FAIL done_hold got yes=%0d no=%0d rej=%b done=%b exp yes=%0d no=%0d rej=0 done=1",
                         yes_cnt, no_cnt, reject, done, y0, n0);
            end
        end
        vote_valid = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || yes_cnt !== '0 || no_cnt !== '0 || result !== 1'b0) begin
            failures++;
            $display("FAIL restart got busy=%b done=%b yes=%0d no=%0d res=%b exp busy=1 done=0 yes=0 no=0 res=0",
                     busy, done, yes_cnt, no_cnt, result);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_full_ballot();
        test_duplicate();
        test_timeout();
        test_last_cycle_ballot();
        test_async_reset_and_sweep();
        test_random();
        test_done_hold();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vote_collector.md
Name: vote_collector

Overview:
- Sequential counterpart to the combinational 5-input majority Voter.
- Collects ballots one at a time over a valid/ready handshake, each tagged with a voter ID.
- Rejects duplicate and out-of-range IDs, closes the ballot when all voters have voted or a timeout expires, then publishes the majority result and the tallies.
- Sits between serial vote sources (UART/bus front-ends) and downstream logic that consumes a latched majority decision.

Parameters:
- N_VOTERS, 5, number of eligible voters; legal IDs are 0..N_VOTERS-1; range 1..(2**ID_W).
- ID_W, 3, width of vote_id.
- TIMEOUT, 32, cycles in COLLECT before the ballot is force-closed; must be >= 1.
- CNT_W, 3, width of yes_cnt/no_cnt; must satisfy 2**CNT_W > N_VOTERS.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  opens a new ballot; sampled only in IDLE or DONE.
- vote_valid  input  1  ballot offered.
- vote_ready  output  1  collector accepts a ballot this cycle.
- vote_id  input  ID_W  voter identifier.
- vote_val  input  1  1 = yes, 0 = no.
- busy  output  1  ballot open (COLLECT state).
- done  output  1  result valid; held until next start.
- result  output  1  majority decision.
- yes_cnt  output  CNT_W  accepted yes votes.
- no_cnt  output  CNT_W  accepted no votes.
- reject  output  1  one-cycle pulse: handshake completed but ballot discarded (duplicate or ID >= N_VOTERS).
- timed_out  output  1  set in DONE if the ballot closed by timeout.

Behaviour:
- Reset (async): state IDLE; vote_ready=0, busy=0, done=0, result=0, yes_cnt=0, no_cnt=0, reject=0, timed_out=0; voted mask cleared; timer cleared.
- States: IDLE, COLLECT, DONE.
- IDLE -> COLLECT on start=1.
  - Clears mask, counts, timer, done, result and timed_out at that edge.
- COLLECT:
  - busy=1; vote_ready=1 combinationally while in COLLECT.
  - Handshake = vote_valid & vote_ready, sampled on the clock edge.
  - Accepted ballot (ID < N_VOTERS and mask[ID]=0): sets mask[ID]; increments yes_cnt or no_cnt per vote_val.
  - Discarded ballot (duplicate or out-of-range): counts and mask unchanged; reject=1 in the following cycle, one cycle wide.
  - Timer increments every COLLECT cycle, including cycles with a handshake.
  - Exit to DONE on the edge where either:
    - the accepted count reaches N_VOTERS, counting the ballot on that edge; or
    - the timer reaches TIMEOUT-1. Set timed_out=1 only if the mask is not full after that edge's ballot is applied.
  - Simultaneous final ballot and timeout: the ballot is counted, and because the mask is then full, timed_out=0.
- Decision is registered on entry to DONE: result = (yes_cnt_next > N_VOTERS/2), using integer division.
  - Absent voters count as no. For N_VOTERS=5, 3 yes votes are required.
- DONE:
  - done=1, busy=0, vote_ready=0.
  - Ballots offered in DONE are not accepted and do not pulse reject.
  - Outputs hold until start.
- start in DONE: next edge enters COLLECT with the same clearing as from IDLE.
- start in COLLECT: ignored.
- Latency: done rises 1 cycle after the closing handshake edge; result, yes_cnt and no_cnt are valid in the same cycle as done.
- Wrap-around: counters cannot overflow because each ID is counted at most once and 2**CNT_W > N_VOTERS.
- Reset mid-ballot aborts immediately to IDLE with all outputs cleared. No partial result is retained.

Test Plan:
1. start; IDs 0..4 with values 1,1,1,0,0 on consecutive cycles -> done one cycle after ID 4; result=1, yes_cnt=3, no_cnt=2, timed_out=0, reject never asserted.
2. start; IDs 0,1 yes then ID 1 again with vote_val=1, then IDs 2,3,4 no -> reject pulses once after the duplicate; yes_cnt=2, no_cnt=3, result=0.
3. start; ID 6 offered, then only IDs 0,1,2 yes; wait -> reject pulses for ID 6; done at cycle TIMEOUT after start; timed_out=1, yes_cnt=3, result=1.
4. start; 4 ballots, then the 5th ballot lands exactly on the timer's TIMEOUT-1 cycle -> ballot counted, timed_out=0, all counts sum to 5.
5. Assert rst asynchronously (between clock edges) mid-COLLECT after 3 votes -> all outputs 0 immediately. A new start, driving all 5 inputs through the full in=0..31 vote-pattern sweep, gives result matching the combinational majority for every pattern.
6. In DONE, drive vote_valid with ID 0 -> vote_ready=0, no count change, no reject. Then assert start -> counts cleared and busy=1 the next cycle.
